// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Imported by the clear sequencer and the top level.
package regfile_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } rf_state_t;

   localparam int RD_PORTS_MAX = 4;

   // Highest register index for a given index width; entry 0 is never stored.
   function automatic int max_reg(input int reg_width);
      return (1 << reg_width) - 1;
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks entries 1..MAX_REG writing zero, one per cycle,
// after reset or on an i_clear request while ready.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int REG_WIDTH = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clear,
   output logic                 o_busy,
   output logic                 o_clr_we,
   output logic [REG_WIDTH-1:0] o_clr_reg,
   output rf_state_t            o_state
);

   localparam logic [REG_WIDTH-1:0] LAST_REG = REG_WIDTH'(max_reg(REG_WIDTH));
   localparam logic [REG_WIDTH-1:0] FIRST_REG = REG_WIDTH'(1);

   rf_state_t            state;
   logic [REG_WIDTH-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= ST_CLEAR;
         cnt   <= FIRST_REG;
      end else begin
         case (state)
            ST_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_REG) state <= ST_READY;
            end
            ST_READY: begin
               if (i_clear) begin
                  state <= ST_CLEAR;
                  cnt   <= FIRST_REG;
               end
            end
            default: begin
               state <= ST_CLEAR;
               cnt   <= FIRST_REG;
            end
         endcase
      end
   end

   assign o_state   = state;
   assign o_busy    = (state == ST_CLEAR);
   assign o_clr_we  = (state == ST_CLEAR);
   assign o_clr_reg = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: RD_PORTS combinational reads, two prioritised
// write ports, optional same-cycle bypass, sequenced clear. r0 reads as zero.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int RD_PORTS   = 2,
   parameter int BYPASS     = 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_clear,
   output logic                           o_ready,
   input  logic                           i_we0,
   input  logic [REG_WIDTH-1:0]           i_wr_reg0,
   input  logic [DATA_WIDTH-1:0]          i_wr_data0,
   input  logic                           i_we1,
   input  logic [REG_WIDTH-1:0]           i_wr_reg1,
   input  logic [DATA_WIDTH-1:0]          i_wr_data1,
   input  logic [RD_PORTS*REG_WIDTH-1:0]  i_rd_reg,
   output logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data
);

   localparam int MAX_REG = max_reg(REG_WIDTH);

   logic                 busy;
   logic                 clr_we;
   logic [REG_WIDTH-1:0] clr_reg;
   rf_state_t            seq_state;

   regfile_clear_seq #(.REG_WIDTH(REG_WIDTH)) u_clear_seq (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (i_clear),
      .o_busy    (busy),
      .o_clr_we  (clr_we),
      .o_clr_reg (clr_reg),
      .o_state   (seq_state)
   );

   // Gating with i_rst keeps outputs quiet while reset is held, even before
   // the sequencer has seen its first edge.
   logic active;
   logic clr_en;
   logic wr0_en;
   logic wr1_en;

   assign active  = i_rst && !busy;
   assign clr_en  = i_rst && clr_we;
   assign wr0_en  = active && i_we0 && (i_wr_reg0 != '0);
   assign wr1_en  = active && i_we1 && (i_wr_reg1 != '0);
   assign o_ready = i_rst && (seq_state == ST_READY);

   logic [DATA_WIDTH-1:0] mem [1:MAX_REG];

   always_ff @(posedge i_clk) begin
      for (int e = 1; e <= MAX_REG; e++) begin
         if (clr_en && clr_reg == REG_WIDTH'(e))
            mem[e] <= '0;
         else if (wr1_en && i_wr_reg1 == REG_WIDTH'(e))
            mem[e] <= i_wr_data1;
         else if (wr0_en && i_wr_reg0 == REG_WIDTH'(e))
            mem[e] <= i_wr_data0;
      end
   end

   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [REG_WIDTH-1:0]  idx;
      logic [DATA_WIDTH-1:0] data;

      assign idx = i_rd_reg[k*REG_WIDTH +: REG_WIDTH];

      always_comb begin
         data = '0;
         if (active && idx != '0) begin
            if (BYPASS != 0 && wr1_en && i_wr_reg1 == idx)
               data = i_wr_data1;
            else if (BYPASS != 0 && wr0_en && i_wr_reg0 == idx)
               data = i_wr_data0;
            else
               data = mem[idx];
         end
      end

      assign o_rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
   end

endmodule
